// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and buffered load returns onto the register file write port, with a pending-load scoreboard
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid_i,
  input  logic [ADDR_W-1:0]    alu_rd_i,
  input  logic [DATA_W-1:0]    alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [ADDR_W-1:0]    lsu_rd_i,
  input  logic [DATA_W-1:0]    lsu_data_i,
  input  logic                 issue_en_i,
  input  logic                 issue_is_load_i,
  input  logic [ADDR_W-1:0]    issue_rd_i,
  input  logic [ADDR_W-1:0]    rs1_addr_i,
  input  logic [ADDR_W-1:0]    rs2_addr_i,
  output logic                 stall_o,
  output logic                 wb_stall_o,
  output logic [2**ADDR_W-1:0] busy_o,
  output logic                 regw_en_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  output logic [DATA_W-1:0]    rd_data_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [CW-1:0] sc, sc_n;
  logic [2**ADDR_W-1:0] busy, busy_n;
  logic push, pop, empty;
  assign empty = cnt == '0;
  assign lsu_ready_o = cnt < (PW+1)'(FIFO_DEPTH);
  assign push = lsu_valid_i && lsu_ready_o;
  assign pop = !alu_valid_i && !empty;
  assign sc_n = (empty || pop) ? '0 : (sc == CW'(STARVE_LIMIT)) ? sc : sc + 1'b1;
  assign busy_o = busy;
  assign stall_o = (rs1_addr_i != '0 && busy[rs1_addr_i]) ||
                   (rs2_addr_i != '0 && busy[rs2_addr_i]) ||
                   (issue_rd_i != '0 && busy[issue_rd_i]);
  always_comb begin
    busy_n = busy;
    if (pop) busy_n[fa[rp]] = 1'b0;
    if (issue_en_i && issue_is_load_i) busy_n[issue_rd_i] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      sc <= '0;
      busy <= '0;
      wb_stall_o <= 1'b0;
      regw_en_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      if (push) begin
        fd[wp] <= lsu_data_i;
        fa[wp] <= lsu_rd_i;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      sc <= sc_n;
      wb_stall_o <= sc_n >= CW'(STARVE_LIMIT - 1);
      busy <= busy_n;
      if (alu_valid_i) begin
        regw_en_o <= alu_rd_i != '0;
        rd_addr_o <= alu_rd_i;
        rd_data_o <= alu_data_i;
      end else if (pop) begin
        regw_en_o <= fa[rp] != '0;
        rd_addr_o <= fa[rp];
        rd_data_o <= fd[rp];
      end else begin
        regw_en_o <= 1'b0;
      end
    end
  end
endmodule
